// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_e;

  localparam int ERR_CNT_W = 8;

  // Slot index width; never narrower than one bit.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index for the TDM demux: wraps after NCH-1, with load-to-1 and clear-to-0.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int SW  = slot_w(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          load1_i,
  input  logic          clr_i,
  output logic [SW-1:0] slot_o
);

  logic [SW-1:0] slot_q, slot_d;

  // Clear wins over load, load over increment.
  always_comb begin
    slot_d = slot_q;
    if (clr_i)
      slot_d = '0;
    else if (load1_i)
      slot_d = SW'(1);
    else if (inc_i)
      slot_d = (slot_q == SW'(NCH - 1)) ? '0 : slot_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// Time-division demux with hunt/sync frame alignment.
// Optional saturating alignment-error counter: define TDM_DEMUX_ERR_CNT_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_data,
  input  logic                 in_sof,
  output logic [NCH*W-1:0]     ch_data,
  output logic [NCH-1:0]       ch_valid,
  output logic                 frame_valid,
  output logic                 sync_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int SW = slot_w(NCH);

  state_e                 state_q, state_d;
  logic                   frame_ok_q, frame_ok_d;
  logic [SW-1:0]          slot;
  logic                   slot_inc, slot_load1, slot_clr;
  logic                   wr, err, fv;
  logic [SW-1:0]          wr_idx;
  logic [NCH-1:0]         wr_en;
  logic [NCH-1:0][W-1:0]  ch_q;
  logic [NCH-1:0]         ch_valid_q;
  logic                   frame_valid_q, sync_err_q;

  tdm_slot_counter #(.NCH(NCH), .SW(SW)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (slot_inc),
    .load1_i (slot_load1),
    .clr_i   (slot_clr),
    .slot_o  (slot)
  );

  always_comb begin
    state_d    = state_q;
    frame_ok_d = frame_ok_q;
    slot_inc   = 1'b0;
    slot_load1 = 1'b0;
    slot_clr   = 1'b0;
    wr         = 1'b0;
    wr_idx     = '0;
    err        = 1'b0;
    fv         = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (in_valid && in_sof) begin
          wr         = 1'b1;
          slot_load1 = 1'b1;
          frame_ok_d = 1'b1;
          state_d    = SYNC;
        end
      end
      SYNC: begin
        if (in_valid) begin
          if (in_sof) begin
            // An early SOF abandons the partial frame and restarts at slot 0.
            err        = (slot != '0);
            wr         = 1'b1;
            slot_load1 = 1'b1;
            frame_ok_d = 1'b1;
          end else if (slot == '0) begin
            err        = 1'b1;
            slot_clr   = 1'b1;
            frame_ok_d = 1'b0;
            state_d    = HUNT;
          end else begin
            wr       = 1'b1;
            wr_idx   = slot;
            slot_inc = 1'b1;
            if (slot == SW'(NCH - 1)) begin
              fv         = frame_ok_q;
              frame_ok_d = 1'b0;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    wr_en = '0;
    for (int k = 0; k < NCH; k++)
      wr_en[k] = wr && (wr_idx == SW'(k));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      frame_ok_q    <= 1'b0;
      ch_q          <= '0;
      ch_valid_q    <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_ok_q    <= frame_ok_d;
      for (int k = 0; k < NCH; k++)
        if (wr_en[k]) ch_q[k] <= in_data;
      ch_valid_q    <= wr_en;
      frame_valid_q <= fv;
      sync_err_q    <= err;
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (err && (err_cnt_q != '1))
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign ch_data     = ch_q;
  assign ch_valid    = ch_valid_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == SYNC);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (NCH=4, W=8).
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;
`ifdef TDM_DEMUX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_sof;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_valid;
  logic             frame_valid;
  logic             sync_err;
  logic             locked;
  logic [7:0]       err_cnt;

  int tests = 0;
  int fails = 0;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sof      (in_sof),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Present inputs at a negedge; return at the next negedge with the result visible.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int i = 0; i < NCH; i++) drive(1'b1, i == 0, f[i*8 +: 8]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b1, 8'hFF);
    tests++; if (ch_data !== 32'h0) begin fails++; $display("FAIL reset_ch_data: got %h exp 00000000", ch_data); end
    tests++; if (ch_valid !== 4'b0) begin fails++; $display("FAIL reset_ch_valid: got %b exp 0000", ch_valid); end
    tests++; if ({frame_valid, sync_err, locked} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b exp 000", {frame_valid, sync_err, locked}); end
    tests++; if (err_cnt !== 8'h0) begin fails++; $display("FAIL reset_err_cnt: got %h exp 00", err_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [3:0] exp_cv;
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      drive(1'b1, i == 0, 8'hA0 + 8'(i));
      exp_cv = 4'b0001 << i;
      tests++; if (ch_valid !== exp_cv) begin fails++; $display("FAIL frame_cv%0d: got %b exp %b", i, ch_valid, exp_cv); end
      tests++; if (frame_valid !== (i == NCH - 1)) begin fails++; $display("FAIL frame_fv%0d: got %b exp %b", i, frame_valid, i == NCH - 1); end
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL frame_locked%0d: got %b exp 1", i, locked); end
    end
    tests++; if (ch_data !== 32'hA3A2A1A0) begin fails++; $display("FAIL frame_data: got %h exp A3A2A1A0", ch_data); end
    drive(1'b0, 1'b0, 8'h00);
    tests++; if ({ch_valid, frame_valid, sync_err} !== 6'b0) begin fails++; $display("FAIL frame_idle: got %b exp 000000", {ch_valid, frame_valid, sync_err}); end
    tests++; if (ch_data !== 32'hA3A2A1A0) begin fails++; $display("FAIL frame_hold: got %h exp A3A2A1A0", ch_data); end
  endtask

  task automatic test_hunt_drop();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 8'h11 : 8'h22;
      drive(1'b1, 1'b0, d);
      tests++; if ({ch_valid, locked, sync_err} !== 6'b0) begin fails++; $display("FAIL hunt_drop%0d: got %b exp 000000", i, {ch_valid, locked, sync_err}); end
    end
    tests++; if (ch_data !== 32'h0) begin fails++; $display("FAIL hunt_data: got %h exp 00000000", ch_data); end
  endtask

  task automatic test_early_sof();
    do_reset();
    send_frame(32'hA3A2A1A0);
    drive(1'b1, 1'b1, 8'hB0);
    drive(1'b1, 1'b0, 8'hB1);
    drive(1'b1, 1'b1, 8'h55);
    tests++; if (sync_err !== 1'b1) begin fails++; $display("FAIL early_err: got %b exp 1", sync_err); end
    tests++; if (ch_valid !== 4'b0001) begin fails++; $display("FAIL early_cv: got %b exp 0001", ch_valid); end
    tests++; if (ch_data[7:0] !== 8'h55) begin fails++; $display("FAIL early_ch0: got %h exp 55", ch_data[7:0]); end
    tests++; if ({frame_valid, locked} !== 2'b01) begin fails++; $display("FAIL early_fv_lock: got %b exp 01", {frame_valid, locked}); end
    drive(1'b1, 1'b0, 8'hC1);
    tests++; if ({sync_err, frame_valid} !== 2'b00) begin fails++; $display("FAIL early_c1: got %b exp 00", {sync_err, frame_valid}); end
    drive(1'b1, 1'b0, 8'hC2);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL early_c2_fv: got %b exp 0", frame_valid); end
    drive(1'b1, 1'b0, 8'hC3);
    tests++; if ({frame_valid, ch_valid} !== 5'b1_1000) begin fails++; $display("FAIL early_c3: got %b exp 11000", {frame_valid, ch_valid}); end
    tests++; if (ch_data !== 32'hC3C2B155 && ch_data !== 32'hC3C2C155) begin fails++; $display("FAIL early_data: got %h exp C3C2C155", ch_data); end
    tests++; if (ch_data !== 32'hC3C2C155) begin fails++; $display("FAIL early_data_exact: got %h exp C3C2C155", ch_data); end
  endtask

  task automatic test_missing_sof();
    // Continues from test_early_sof: locked at slot 0, ch_data = C3C2C155.
    drive(1'b1, 1'b0, 8'h77);
    tests++; if ({sync_err, locked} !== 2'b10) begin fails++; $display("FAIL miss_err_lock: got %b exp 10", {sync_err, locked}); end
    tests++; if ({ch_valid, frame_valid} !== 5'b0) begin fails++; $display("FAIL miss_cv_fv: got %b exp 00000", {ch_valid, frame_valid}); end
    tests++; if (ch_data !== 32'hC3C2C155) begin fails++; $display("FAIL miss_data: got %h exp C3C2C155", ch_data); end
    drive(1'b1, 1'b0, 8'h78);
    tests++; if ({sync_err, ch_valid, locked} !== 6'b0) begin fails++; $display("FAIL miss_hunt: got %b exp 000000", {sync_err, ch_valid, locked}); end
    drive(1'b1, 1'b1, 8'hD0);
    tests++; if ({locked, ch_valid} !== 5'b1_0001) begin fails++; $display("FAIL miss_relock: got %b exp 10001", {locked, ch_valid}); end
  endtask

  task automatic test_gaps();
    int fv_cnt = 0;
    int cv_cnt = 0;
    logic [31:0] f = 32'hE3E2E1E0;
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      for (int g = 0; g < i; g++) begin
        drive(1'b0, 1'b0, 8'hEE);
        fv_cnt += int'(frame_valid);
        cv_cnt += $countones(ch_valid);
      end
      drive(1'b1, i == 0, f[i*8 +: 8]);
      fv_cnt += int'(frame_valid);
      cv_cnt += $countones(ch_valid);
    end
    drive(1'b0, 1'b0, 8'h00);
    fv_cnt += int'(frame_valid);
    tests++; if (ch_data !== f) begin fails++; $display("FAIL gaps_data: got %h exp %h", ch_data, f); end
    tests++; if (fv_cnt !== 1) begin fails++; $display("FAIL gaps_fv_count: got %0d exp 1", fv_cnt); end
    tests++; if (cv_cnt !== 4) begin fails++; $display("FAIL gaps_cv_count: got %0d exp 4", cv_cnt); end
  endtask

  task automatic test_err_cnt();
    logic [7:0] exp1, exp255;
    exp1   = CNT_EN ? 8'd1 : 8'd0;
    exp255 = CNT_EN ? 8'd255 : 8'd0;
    do_reset();
    for (int e = 0; e < 300; e++) begin
      send_frame(32'h03020100);
      drive(1'b1, 1'b0, 8'h99);
      if (e == 0) begin
        tests++; if ({sync_err, err_cnt} !== {1'b1, exp1}) begin fails++; $display("FAIL errcnt_first: got %b/%h exp 1/%h", sync_err, err_cnt, exp1); end
      end
    end
    tests++; if (err_cnt !== exp255) begin fails++; $display("FAIL errcnt_sat: got %h exp %h", err_cnt, exp255); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(32'h13121110);
    drive(1'b1, 1'b1, 8'h20);
    drive(1'b1, 1'b0, 8'h21);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h22);
    rst_n = 1'b1;
    tests++; if ({ch_data, ch_valid, frame_valid, sync_err, locked, err_cnt} !== '0) begin fails++; $display("FAIL midrst_zero: got %h/%b/%b%b%b/%h exp all 0", ch_data, ch_valid, frame_valid, sync_err, locked, err_cnt); end
    drive(1'b1, 1'b0, 8'h23);
    tests++; if ({ch_valid, locked} !== 5'b0) begin fails++; $display("FAIL midrst_nosof: got %b exp 00000", {ch_valid, locked}); end
    drive(1'b1, 1'b1, 8'h30);
    tests++; if ({locked, ch_valid} !== 5'b1_0001) begin fails++; $display("FAIL midrst_relock: got %b exp 10001", {locked, ch_valid}); end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    @(negedge clk);
    test_reset();
    test_frame();
    test_hunt_drop();
    test_early_sof();
    test_missing_sof();
    test_gaps();
    test_err_cnt();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
